// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM generator: mode encoding and the
// default counter width.
package pwm_pkg;

   localparam int DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      MODE_LEFT    = 2'b00,
      MODE_RIGHT   = 2'b01,
      MODE_UNALIGN = 2'b10
   } pwm_mode_e;

   // Register-side encoding treats any value with bit 1 set as unaligned.
   function automatic pwm_mode_e decode_mode(input logic [1:0] functions);
      pwm_mode_e mode;
      if (functions[1]) begin
         mode = MODE_UNALIGN;
      end else if (functions[0]) begin
         mode = MODE_RIGHT;
      end else begin
         mode = MODE_LEFT;
      end
      return mode;
   endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// Period-boundary detection and double-buffered compare/mode shadows.
// Outputs the values in force for the current cycle plus a registered boundary strobe.
module pwm_shadow_reg
   import pwm_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count_val,
   input  logic [CNT_W-1:0] period,
   input  logic             upnotdown,
   input  logic             pwm_en,
   input  logic [CNT_W-1:0] compare1,
   input  logic [CNT_W-1:0] compare2,
   input  logic [1:0]       functions,
   output logic [CNT_W-1:0] cmp1,
   output logic [CNT_W-1:0] cmp2,
   output pwm_mode_e        mode,
   output logic             period_pulse
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] prev_count;
   logic [CNT_W-1:0] c1_q;
   logic [CNT_W-1:0] c2_q;
   pwm_mode_e        mode_q;
   logic             armed;
   logic             boundary;
   logic             load;

   // A held count (prescale stall) never matches because prev_count equals count_val.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      boundary = 1'b0;
      if ((period != '0) && (count_val != prev_count)) begin
         if (upnotdown) begin
            boundary = (count_val == '0);
         end else begin
            boundary = (count_val == (period - ONE));
         end
      end
   end

   // While disabled the shadows are frozen; re-enabling reloads them anyway.
   assign load = pwm_en && (boundary || !armed);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         // NOTE: the shadows are a handful of flops, not a memory, so they take an
         // explicit reset value like any other control register.
         prev_count   <= '0;
         armed        <= 1'b0;
         c1_q         <= '0;
         c2_q         <= '0;
         mode_q       <= MODE_LEFT;
         period_pulse <= 1'b0;
      end else begin
         prev_count   <= count_val;
         armed        <= pwm_en;
         period_pulse <= boundary;
         if (load) begin
            c1_q   <= compare1;
            c2_q   <= compare2;
            mode_q <= decode_mode(functions);
         end
      end
   end

   // The first count of a new period (or of a fresh enable) already uses the new values.
   always_comb begin
      cmp1 = c1_q;
      cmp2 = c2_q;
      mode = mode_q;
      if (load) begin
         cmp1 = compare1;
         cmp2 = compare2;
         mode = decode_mode(functions);
      end
   end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator top: compares the live count against the shadowed compare
// values and drives one registered PWM output.
module pwm_gen
   import pwm_pkg::*;
#(
   parameter int   CNT_W    = DEF_CNT_W,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count_val,
   input  logic [CNT_W-1:0] period,
   input  logic             upnotdown,
   input  logic             pwm_en,
   input  logic [CNT_W-1:0] compare1,
   input  logic [CNT_W-1:0] compare2,
   input  logic [1:0]       functions,
   output logic             pwm_out,
   output logic             period_pulse
);

   logic [CNT_W-1:0] cmp1;
   logic [CNT_W-1:0] cmp2;
   pwm_mode_e        mode;
   logic             cmp_hit;

   pwm_shadow_reg #(
      .CNT_W(CNT_W)
   ) u_shadow (
      .clk          (clk),
      .rst          (rst),
      .count_val    (count_val),
      .period       (period),
      .upnotdown    (upnotdown),
      .pwm_en       (pwm_en),
      .compare1     (compare1),
      .compare2     (compare2),
      .functions    (functions),
      .cmp1         (cmp1),
      .cmp2         (cmp2),
      .mode         (mode),
      .period_pulse (period_pulse)
   );

   // Plain unsigned compares give the edge cases for free: c1=0 and c1>=period
   // saturate because count_val never leaves 0..period-1.
   always_comb begin
      cmp_hit = 1'b0;
      unique case (mode)
         MODE_LEFT:    cmp_hit = (count_val < cmp1);
         MODE_RIGHT:   cmp_hit = (count_val >= cmp1);
         MODE_UNALIGN: cmp_hit = (count_val >= cmp1) && (count_val < cmp2);
         default:      cmp_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || !pwm_en) begin
         pwm_out <= IDLE_LVL;
      end else begin
         pwm_out <= cmp_hit;
      end
   end

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: a software counter drives count_val, a
// period-level model predicts pwm_out/period_pulse, directed scenarios pin it.
module tb_pwm_gen;

   localparam int   CNT_W    = 16;
   localparam logic IDLE_LVL = 1'b0;

   logic             clk = 1'b0;
   logic             rst;
   logic [CNT_W-1:0] count_val;
   logic [CNT_W-1:0] period;
   logic             upnotdown;
   logic             pwm_en;
   logic [CNT_W-1:0] compare1;
   logic [CNT_W-1:0] compare2;
   logic [1:0]       functions;
   logic             pwm_out;
   logic             period_pulse;

   always #5 clk = ~clk;

   pwm_gen #(
      .CNT_W    (CNT_W),
      .IDLE_LVL (IDLE_LVL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .count_val    (count_val),
      .period       (period),
      .upnotdown    (upnotdown),
      .pwm_en       (pwm_en),
      .compare1     (compare1),
      .compare2     (compare2),
      .functions    (functions),
      .pwm_out      (pwm_out),
      .period_pulse (period_pulse)
   );

   int n_vec  = 0;
   int n_miss = 0;

   // Software prescaled counter feeding count_val.
   int sw_cnt     = 0;
   int sw_phase   = 0;
   int presc_len  = 1;

   // Model: settings in force for the current period and what was seen last cycle.
   int         m_prev    = 0;
   bit         m_en_last = 1'b0;
   int         m_c1      = 0;
   int         m_c2      = 0;
   logic [1:0] m_func    = 2'b00;
   logic       exp_pwm;
   logic       exp_pulse;

   int hi_acc    = 0;
   int pulse_acc = 0;
   int hi_base   = 0;
   int pulse_base = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic logic level(input logic [1:0] f, input int c1, input int c2, input int cnt);
      if (f[1]) return (cnt >= c1) && (cnt < c2);
      if (f[0]) return cnt >= c1;
      return cnt < c1;
   endfunction

   task automatic model_step();
      int cnt;
      int start;
      bit bnd;
      cnt = int'(count_val);
      if (rst) begin
         exp_pwm   = IDLE_LVL;
         exp_pulse = 1'b0;
         m_prev    = 0;
         m_en_last = 1'b0;
         m_c1      = 0;
         m_c2      = 0;
         m_func    = 2'b00;
      end else begin
         start = upnotdown ? 0 : int'(period) - 1;
         bnd   = (period != 0) && (cnt != m_prev) && (cnt == start);
         if (pwm_en && (bnd || !m_en_last)) begin
            m_c1   = int'(compare1);
            m_c2   = int'(compare2);
            m_func = functions;
         end
         exp_pulse = bnd;
         exp_pwm   = pwm_en ? level(m_func, m_c1, m_c2, cnt) : IDLE_LVL;
         m_prev    = cnt;
         m_en_last = pwm_en;
      end
   endtask

   task automatic restart();
      sw_cnt   = (upnotdown || period == 0) ? 0 : int'(period) - 1;
      sw_phase = 0;
   endtask

   // One clock: apply count, predict, advance counter, then compare after the edge.
   task automatic cycle();
      count_val = CNT_W'(sw_cnt);
      model_step();
      if (sw_phase >= presc_len - 1) begin
         sw_phase = 0;
         if (period == 0) sw_cnt = 0;
         else if (upnotdown) sw_cnt = (sw_cnt >= int'(period) - 1) ? 0 : sw_cnt + 1;
         else sw_cnt = (sw_cnt == 0 || sw_cnt >= int'(period)) ? int'(period) - 1 : sw_cnt - 1;
      end else begin
         sw_phase++;
      end
      @(posedge clk);
      #1;
      check("pwm_out", pwm_out, exp_pwm);
      check("period_pulse", period_pulse, exp_pulse);
      if (pwm_out === 1'b1) hi_acc++;
      if (period_pulse === 1'b1) pulse_acc++;
   endtask

   task automatic wait_count(input int v);
      int budget;
      budget = 200;
      while (!(sw_cnt == v && sw_phase == 0) && budget > 0) begin
         cycle();
         budget--;
      end
      if (budget == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL wait_count: counter never reached %0d, at %0d", v, sw_cnt);
      end
   endtask

   task automatic win_begin();
      hi_base    = hi_acc;
      pulse_base = pulse_acc;
   endtask

   task automatic win_end(input string name, input int want_hi, input int want_pulse);
      check({name, "_high_clks"}, hi_acc - hi_base, want_hi);
      check({name, "_pulses"}, pulse_acc - pulse_base, want_pulse);
   endtask

   task automatic window(input string name, input int n, input int want_hi, input int want_pulse);
      win_begin();
      repeat (n) cycle();
      win_end(name, want_hi, want_pulse);
   endtask

   initial begin
      rst       = 1'b1;
      pwm_en    = 1'b1;
      upnotdown = 1'b1;
      period    = 16'd10;
      compare1  = 16'd3;
      compare2  = 16'd0;
      functions = 2'b00;
      count_val = '0;
      cycle();
      cycle();
      check("reset_pwm_out", pwm_out, IDLE_LVL);
      check("reset_period_pulse", period_pulse, 1'b0);

      // Left aligned, c1=3, period 10, no prescale.
      rst = 1'b0;
      restart();
      repeat (10) cycle();
      wait_count(0);
      window("left_c1_3", 10, 3, 1);
      wait_count(2);
      cycle();
      check("left_cnt2_high", pwm_out, 1'b1);
      cycle();
      check("left_cnt3_low", pwm_out, 1'b0);

      // Mid-period write of c1=7 only takes effect at the next period.
      wait_count(0);
      win_begin();
      repeat (5) cycle();
      compare1 = 16'd7;
      repeat (5) cycle();
      win_end("midwrite_cur", 3, 1);
      window("midwrite_next", 10, 7, 1);

      // Unaligned, down count, period 8.
      upnotdown = 1'b0;
      period    = 16'd8;
      functions = 2'b10;
      compare1  = 16'd2;
      compare2  = 16'd6;
      restart();
      repeat (8) cycle();
      wait_count(7);
      window("unalign_2_6", 8, 4, 1);
      wait_count(7);
      win_begin();
      repeat (4) cycle();
      compare1 = 16'd6;
      compare2 = 16'd2;
      repeat (4) cycle();
      win_end("unalign_swap_cur", 4, 1);
      window("unalign_swap_next", 8, 0, 1);

      // Edge compare values.
      upnotdown = 1'b1;
      period    = 16'd10;
      functions = 2'b00;
      compare1  = 16'd0;
      restart();
      repeat (10) cycle();
      window("left_c1_0", 10, 0, 1);
      compare1 = 16'd10;
      repeat (10) cycle();
      window("left_c1_period", 10, 10, 1);
      functions = 2'b01;
      compare1  = 16'd0;
      repeat (10) cycle();
      window("right_c1_0", 10, 10, 1);

      // Prescale by 4: one pulse per period, high time scales.
      functions = 2'b00;
      compare1  = 16'd3;
      presc_len = 4;
      restart();
      repeat (40) cycle();
      wait_count(0);
      window("presc4", 40, 12, 1);

      // Reset and disable mid-period, then immediate reload.
      presc_len = 1;
      restart();
      repeat (10) cycle();
      wait_count(1);
      rst = 1'b1;
      cycle();
      check("midrst_idle", pwm_out, IDLE_LVL);
      rst = 1'b0;
      cycle();
      check("midrst_reload", pwm_out, 1'b1);
      wait_count(1);
      pwm_en = 1'b0;
      cycle();
      check("disable_idle", pwm_out, IDLE_LVL);
      pwm_en = 1'b1;
      cycle();
      check("reenable_reload", pwm_out, 1'b1);
      wait_count(0);
      pwm_en = 1'b0;
      cycle();
      check("disable_at_bnd_pwm", pwm_out, IDLE_LVL);
      check("disable_at_bnd_pulse", period_pulse, 1'b1);
      pwm_en = 1'b1;

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 299) == 0) begin
            period    = CNT_W'($urandom_range(0, 12));
            upnotdown = 1'($urandom_range(0, 1));
            presc_len = 1 << $urandom_range(0, 2);
            restart();
         end
         if ($urandom_range(0, 7) == 0) compare1 = CNT_W'($urandom_range(0, int'(period) + 2));
         if ($urandom_range(0, 7) == 0) compare2 = CNT_W'($urandom_range(0, int'(period) + 2));
         if ($urandom_range(0, 15) == 0) functions = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) pwm_en = ~pwm_en;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
